// File: rtl/rs_alu.sv
// rs_alu: ALU reservation station with CDB snooping and registered dispatch; define RS_AGE_ORDER_EN to dispatch oldest-ready first
module rs_alu #(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        issue_sgn,
  input  logic [5:0]  issue_opcode,
  input  logic [31:0] issue_vj,
  input  logic [31:0] issue_vk,
  input  logic        issue_qj_busy,
  input  logic        issue_qk_busy,
  input  logic [5:0]  issue_qj,
  input  logic [5:0]  issue_qk,
  input  logic [31:0] issue_imm,
  input  logic [31:0] issue_pc,
  input  logic [5:0]  issue_rob_entry,
  output logic        rs_full,
  input  logic        alu_cdb_sgn,
  input  logic [5:0]  alu_cdb_rob,
  input  logic [31:0] alu_cdb_value,
  input  logic        lsb_cdb_sgn,
  input  logic [5:0]  lsb_cdb_rob,
  input  logic [31:0] lsb_cdb_value,
  input  logic        rob_clear,
  output logic        alu_sgn,
  output logic [5:0]  alu_opcode,
  output logic [31:0] alu_lhs,
  output logic [31:0] alu_rhs,
  output logic [31:0] alu_imm,
  output logic [31:0] alu_pc,
  output logic [5:0]  alu_rob_entry
);
  localparam int AW = $clog2(DEPTH);
  logic [DEPTH-1:0] valid, qj_busy, qk_busy, ready, pick, valid_nx, qj_busy_nx, qk_busy_nx;
  logic [5:0]  opcode [DEPTH];
  logic [5:0]  qj [DEPTH];
  logic [5:0]  qk [DEPTH];
  logic [5:0]  rob [DEPTH];
  logic [31:0] vj [DEPTH];
  logic [31:0] vk [DEPTH];
  logic [31:0] imm [DEPTH];
  logic [31:0] pc [DEPTH];
  logic [31:0] vj_nx [DEPTH];
  logic [31:0] vk_nx [DEPTH];
  logic [AW-1:0] free_idx, sel_idx;
  logic free_ok, sel_ok, alloc;
`ifdef RS_AGE_ORDER_EN
  logic [DEPTH-1:0] older [DEPTH];
`endif

  function automatic logic hit(input logic [5:0] t);
    return (alu_cdb_sgn && alu_cdb_rob == t) || (lsb_cdb_sgn && lsb_cdb_rob == t);
  endfunction

  // the ALU bus wins when both buses carry the same tag
  function automatic logic [31:0] snoop(input logic [5:0] t, input logic [31:0] old);
    return (alu_cdb_sgn && alu_cdb_rob == t) ? alu_cdb_value :
           (lsb_cdb_sgn && lsb_cdb_rob == t) ? lsb_cdb_value : old;
  endfunction

  // ready mask, selection among ready entries and lowest free slot
  always_comb begin
    ready = valid & ~qj_busy & ~qk_busy;
`ifdef RS_AGE_ORDER_EN
    for (int i = 0; i < DEPTH; i++) begin
      pick[i] = ready[i];
      for (int j = 0; j < DEPTH; j++) if (ready[j] && older[j][i]) pick[i] = 1'b0;
    end
`else
    pick = ready;
`endif
    free_idx = '0;
    sel_idx = '0;
    free_ok = 1'b0;
    sel_ok = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid[i]) begin free_idx = AW'(i); free_ok = 1'b1; end
      if (pick[i]) begin sel_idx = AW'(i); sel_ok = 1'b1; end
    end
    alloc = issue_sgn && !rs_full && rdy && free_ok;
  end

  // next valid/busy/operand state: dispatch frees, allocation fills, CDBs wake
  always_comb begin
    valid_nx = valid;
    if (sel_ok) valid_nx[sel_idx] = 1'b0;
    if (alloc) valid_nx[free_idx] = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      qj_busy_nx[i] = qj_busy[i] && !hit(qj[i]);
      qk_busy_nx[i] = qk_busy[i] && !hit(qk[i]);
      vj_nx[i] = qj_busy[i] ? snoop(qj[i], vj[i]) : vj[i];
      vk_nx[i] = qk_busy[i] ? snoop(qk[i], vk[i]) : vk[i];
    end
    if (alloc) begin
      qj_busy_nx[free_idx] = issue_qj_busy && !hit(issue_qj);
      qk_busy_nx[free_idx] = issue_qk_busy && !hit(issue_qk);
      vj_nx[free_idx] = issue_qj_busy ? snoop(issue_qj, issue_vj) : issue_vj;
      vk_nx[free_idx] = issue_qk_busy ? snoop(issue_qk, issue_vk) : issue_vk;
    end
  end

  // control state and registered dispatch outputs; flush beats everything but stall
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      valid <= '0;
      qj_busy <= '0;
      qk_busy <= '0;
      rs_full <= 1'b0;
      alu_sgn <= 1'b0;
      alu_opcode <= '0;
      alu_lhs <= '0;
      alu_rhs <= '0;
      alu_imm <= '0;
      alu_pc <= '0;
      alu_rob_entry <= '0;
    end else if (!rdy) begin
      alu_sgn <= 1'b0;
    end else if (rob_clear) begin
      valid <= '0;
      rs_full <= 1'b0;
      alu_sgn <= 1'b0;
    end else begin
      valid <= valid_nx;
      qj_busy <= qj_busy_nx;
      qk_busy <= qk_busy_nx;
      rs_full <= &valid_nx;
      alu_sgn <= sel_ok;
      if (sel_ok) begin
        alu_opcode <= opcode[sel_idx];
        alu_lhs <= vj[sel_idx];
        alu_rhs <= vk[sel_idx];
        alu_imm <= imm[sel_idx];
        alu_pc <= pc[sel_idx];
        alu_rob_entry <= rob[sel_idx];
      end
    end

  // entry payload and age matrix; meaningful only while the entry is valid
  always_ff @(posedge clk)
    if (rdy && !rob_clear) begin
      vj <= vj_nx;
      vk <= vk_nx;
      if (alloc) begin
        opcode[free_idx] <= issue_opcode;
        qj[free_idx] <= issue_qj;
        qk[free_idx] <= issue_qk;
        imm[free_idx] <= issue_imm;
        pc[free_idx] <= issue_pc;
        rob[free_idx] <= issue_rob_entry;
      end
`ifdef RS_AGE_ORDER_EN
      if (alloc)
        for (int j = 0; j < DEPTH; j++) begin
          older[j][free_idx] <= valid[j];
          older[free_idx][j] <= 1'b0;
        end
`endif
    end
endmodule

// File: tb/tb_rs_alu.sv
// tb_rs_alu: scoreboard bench for rs_alu covering latency, wakeup, full, flush, reset and select order
module tb_rs_alu;
  localparam logic [5:0] ADD = 6'd1;
  localparam logic [5:0] ADDI = 6'd10;
  logic clk = 1'b0, rst = 1'b0, rdy = 1'b1;
  logic issue_sgn = 1'b0, issue_qj_busy = 1'b0, issue_qk_busy = 1'b0;
  logic [5:0] issue_opcode = '0, issue_qj = '0, issue_qk = '0, issue_rob_entry = '0;
  logic [31:0] issue_vj = '0, issue_vk = '0, issue_imm = '0, issue_pc = '0;
  logic alu_cdb_sgn = 1'b0, lsb_cdb_sgn = 1'b0, rob_clear = 1'b0;
  logic [5:0] alu_cdb_rob = '0, lsb_cdb_rob = '0;
  logic [31:0] alu_cdb_value = '0, lsb_cdb_value = '0;
  logic rs_full, alu_sgn;
  logic [5:0] alu_opcode, alu_rob_entry;
  logic [31:0] alu_lhs, alu_rhs, alu_imm, alu_pc;
  int total = 0, bad = 0;
  typedef struct {
    logic [5:0] op;
    logic [31:0] lhs, rhs, imm, pc;
    logic [5:0] rob;
  } exp_t;
  exp_t sb[$];

  rs_alu #(.DEPTH(8)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .issue_sgn(issue_sgn), .issue_opcode(issue_opcode),
    .issue_vj(issue_vj), .issue_vk(issue_vk), .issue_qj_busy(issue_qj_busy),
    .issue_qk_busy(issue_qk_busy), .issue_qj(issue_qj), .issue_qk(issue_qk),
    .issue_imm(issue_imm), .issue_pc(issue_pc), .issue_rob_entry(issue_rob_entry),
    .rs_full(rs_full), .alu_cdb_sgn(alu_cdb_sgn), .alu_cdb_rob(alu_cdb_rob),
    .alu_cdb_value(alu_cdb_value), .lsb_cdb_sgn(lsb_cdb_sgn), .lsb_cdb_rob(lsb_cdb_rob),
    .lsb_cdb_value(lsb_cdb_value), .rob_clear(rob_clear), .alu_sgn(alu_sgn),
    .alu_opcode(alu_opcode), .alu_lhs(alu_lhs), .alu_rhs(alu_rhs), .alu_imm(alu_imm),
    .alu_pc(alu_pc), .alu_rob_entry(alu_rob_entry)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [5:0] op, input logic [31:0] lhs, rhs, im, input logic [5:0] rb);
    exp_t e;
    e.op = op; e.lhs = lhs; e.rhs = rhs; e.imm = im; e.pc = 32'h1000 + 32'(rb); e.rob = rb;
    sb.push_back(e);
  endtask

  task automatic issue(input logic [5:0] op, input logic [31:0] a, b, input logic ja,
                       input logic [5:0] ta, input logic kb, input logic [5:0] tk,
                       input logic [31:0] im, input logic [5:0] rb);
    issue_sgn = 1'b1; issue_opcode = op; issue_vj = a; issue_vk = b;
    issue_qj_busy = ja; issue_qj = ta; issue_qk_busy = kb; issue_qk = tk;
    issue_imm = im; issue_pc = 32'h1000 + 32'(rb); issue_rob_entry = rb;
    tick();
    issue_sgn = 1'b0;
  endtask

  task automatic cdb(input logic alu, input logic [5:0] t, input logic [31:0] v);
    if (alu) begin alu_cdb_sgn = 1'b1; alu_cdb_rob = t; alu_cdb_value = v; end
    else begin lsb_cdb_sgn = 1'b1; lsb_cdb_rob = t; lsb_cdb_value = v; end
  endtask

  // scoreboard: every dispatch must match the next expected record
  always @(negedge clk)
    if (!rst && alu_sgn) begin
      if (sb.size() == 0) check("unexpected_dispatch", {31'b0, alu_sgn}, 32'd0);
      else begin
        exp_t e;
        e = sb.pop_front();
        check("d_rob", 32'(alu_rob_entry), 32'(e.rob));
        check("d_op", 32'(alu_opcode), 32'(e.op));
        check("d_lhs", alu_lhs, e.lhs);
        check("d_rhs", alu_rhs, e.rhs);
        check("d_imm", alu_imm, e.imm);
        check("d_pc", alu_pc, e.pc);
      end
    end

  initial begin
    #1 rst = 1'b1;
    #1;
    check("rst_full", 32'(rs_full), 0);
    check("rst_sgn", 32'(alu_sgn), 0);
    check("rst_lhs", alu_lhs, 0);
    check("rst_rob", 32'(alu_rob_entry), 0);
    tick();
    rst = 1'b0;
    tick();
    push(ADDI, 5, 0, 7, 3);
    issue(ADDI, 5, 0, 0, 0, 0, 0, 7, 3);
    check("t1_not_yet", 32'(alu_sgn), 0);
    tick();
    check("t1_sgn", 32'(alu_sgn), 1);
    tick();
    check("t1_freed", 32'(alu_sgn), 0);
    issue(ADD, 0, 2, 1, 9, 0, 0, 0, 5);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t2_wait", 32'(alu_sgn), 0);
    end
    push(ADD, 32'h10, 2, 0, 5);
    cdb(0, 9, 32'h10);
    tick();
    lsb_cdb_sgn = 1'b0;
    check("t2_capture", 32'(alu_sgn), 0);
    tick();
    check("t2_dispatch", 32'(alu_sgn), 1);
    tick();
    push(ADD, 3, 32'hFFFF_FFFF, 0, 6);
    cdb(1, 4, 32'hFFFF_FFFF);
    issue(ADD, 3, 0, 0, 0, 1, 4, 0, 6);
    alu_cdb_sgn = 1'b0;
    check("t3_not_yet", 32'(alu_sgn), 0);
    tick();
    check("t3_dispatch", 32'(alu_sgn), 1);
    tick();
    issue(ADD, 0, 0, 1, 12, 1, 13, 0, 7);
    push(ADD, 32'hA, 32'hB, 0, 7);
    cdb(1, 12, 32'hA);
    cdb(0, 13, 32'hB);
    tick();
    alu_cdb_sgn = 1'b0;
    lsb_cdb_sgn = 1'b0;
    tick();
    check("t3b_dispatch", 32'(alu_sgn), 1);
    tick();
    push(ADDI, 1, 0, 2, 8);
    issue(ADDI, 1, 0, 0, 0, 0, 0, 2, 8);
    rdy = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("stall", 32'(alu_sgn), 0);
    end
    rdy = 1'b1;
    tick();
    check("stall_release", 32'(alu_sgn), 1);
    tick();
    for (int k = 0; k < 8; k++) begin
      push(ADD, 32'h77, 32'(k), 0, 6'(16 + k));
      issue(ADD, 0, 32'(k), 1, 1, 0, 0, 0, 6'(16 + k));
      if (k == 6) check("t4_not_full", 32'(rs_full), 0);
    end
    check("t4_full", 32'(rs_full), 1);
    issue(ADD, 0, 0, 0, 0, 0, 0, 0, 30);
    check("t4_still_full", 32'(rs_full), 1);
    cdb(1, 1, 32'h77);
    tick();
    alu_cdb_sgn = 1'b0;
    check("t4_capture", 32'(alu_sgn), 0);
    tick();
    check("t4_first", 32'(alu_sgn), 1);
    check("t4_unfull", 32'(rs_full), 0);
    for (int i = 0; i < 8; i++) tick();
    check("t4_drained", sb.size(), 0);
    issue(ADD, 0, 0, 1, 20, 0, 0, 0, 20);
    issue(ADD, 0, 0, 1, 20, 0, 0, 0, 21);
    rob_clear = 1'b1;
    issue(ADD, 0, 0, 0, 0, 0, 0, 0, 22);
    rob_clear = 1'b0;
    check("t5_sgn", 32'(alu_sgn), 0);
    check("t5_full", 32'(rs_full), 0);
    cdb(1, 20, 32'h5);
    tick();
    alu_cdb_sgn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t5_no_dispatch", 32'(alu_sgn), 0);
    end
    issue(ADDI, 32'h55, 0, 0, 0, 0, 0, 32'h66, 23);
    tick();
    check("t6_pre_sgn", 32'(alu_sgn), 1);
    check("t6_pre_lhs", alu_lhs, 32'h55);
    #1 rst = 1'b1;
    #1;
    check("t6_sgn", 32'(alu_sgn), 0);
    check("t6_lhs", alu_lhs, 0);
    check("t6_imm", alu_imm, 0);
    check("t6_op", 32'(alu_opcode), 0);
    check("t6_rob", 32'(alu_rob_entry), 0);
    tick();
    rst = 1'b0;
    tick();
    issue(ADD, 0, 10, 1, 40, 0, 0, 0, 10);
    issue(ADD, 0, 11, 1, 41, 0, 0, 0, 11);
    issue(ADD, 0, 12, 1, 41, 0, 0, 0, 12);
    push(ADD, 32'h400, 10, 0, 10);
    cdb(1, 40, 32'h400);
    tick();
    alu_cdb_sgn = 1'b0;
    tick();
    check("t7_first", 32'(alu_sgn), 1);
    issue(ADD, 0, 13, 1, 41, 0, 0, 0, 13);
`ifdef RS_AGE_ORDER_EN
    push(ADD, 32'h410, 11, 0, 11);
    push(ADD, 32'h410, 12, 0, 12);
    push(ADD, 32'h410, 13, 0, 13);
`else
    push(ADD, 32'h410, 13, 0, 13);
    push(ADD, 32'h410, 11, 0, 11);
    push(ADD, 32'h410, 12, 0, 12);
`endif
    cdb(1, 41, 32'h410);
    tick();
    alu_cdb_sgn = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
